// File: rtl/val2_pkg.sv
// Shared types and constants for the sequential ARM operand-2 shifter.
package val2_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    MODE_IMM32   = 3'd0,
    MODE_MEM     = 3'd1,
    MODE_IMM_ROT = 3'd2,
    MODE_REG_IMM = 3'd3,
    MODE_REG_REG = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    LSL = 2'd0,
    LSR = 2'd1,
    ASR = 2'd2,
    ROR = 2'd3
  } shift_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/val2_shift_step.sv
// Combinational single shift step of k positions (0..2^STEP_LOG2) with carry-out.
module val2_shift_step
  import val2_pkg::*;
#(
  parameter int unsigned STEP_LOG2 = 2
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [STEP_LOG2:0] k,
  input  shift_e             stype,
  input  logic               carry_in,
  output logic [DATA_W-1:0]  result_c,
  output logic               carry_c
);

  localparam int unsigned AW = 7;

  logic [AW-1:0]     amt;
  logic [DATA_W:0]   lsl_ext;
  logic [DATA_W:0]   lsr_ext;
  logic [DATA_W:0]   asr_ext;
  logic [DATA_W-1:0] ror_res;

  assign amt = AW'(k);

  // Guard bit next to the operand catches the last bit shifted out.
  assign lsl_ext = {1'b0, data} << amt;
  assign lsr_ext = {data, 1'b0} >> amt;
  assign asr_ext = $signed({data, 1'b0}) >>> amt;
  assign ror_res = (data >> amt) | (data << (AW'(DATA_W) - amt));

  always_comb begin
    result_c = data;
    carry_c  = carry_in;
    if (k != '0) begin
      case (stype)
        LSL: begin
          result_c = lsl_ext[DATA_W-1:0];
          carry_c  = lsl_ext[DATA_W];
        end
        LSR: begin
          result_c = lsr_ext[DATA_W:1];
          carry_c  = lsr_ext[0];
        end
        ASR: begin
          result_c = asr_ext[DATA_W:1];
          carry_c  = asr_ext[0];
        end
        default: begin
          result_c = ror_res;
          carry_c  = ror_res[DATA_W-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_seq_shifter.sv
// Multi-cycle ARM operand-2 generator: resolves trivial encodings at accept,
// otherwise shifts iteratively 2^STEP_LOG2 positions per cycle.
module val2_seq_shifter
  import val2_pkg::*;
#(
  parameter int unsigned STEP_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs,
  input  logic [DATA_W-1:0] imm32,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              carry_out,
  output logic              busy
);

  localparam int unsigned KW   = STEP_LOG2 + 1;
  localparam int unsigned STEP = 1 << STEP_LOG2;

  state_e            state, state_nxt;
  logic [DATA_W-1:0] work_q, work_nxt;
  logic [4:0]        n_q, n_nxt;
  shift_e            type_q, type_nxt;
  logic [DATA_W-1:0] val_nxt;
  logic              cout_nxt;

  logic              dec_special;
  logic [DATA_W-1:0] dec_val;
  logic              dec_carry;
  logic [DATA_W-1:0] dec_work;
  logic [4:0]        dec_n;
  shift_e            dec_type;

  logic [5:0]        n_wide;
  logic [KW-1:0]     step_k;
  logic [DATA_W-1:0] step_res;
  logic              step_carry;

  // Request decode: either a final result now, or the work to iterate on.
  always_comb begin
    dec_special = 1'b1;
    dec_val     = imm32;
    dec_carry   = carry_in;
    dec_work    = rm;
    dec_n       = '0;
    dec_type    = shift_e'(shift_operand[6:5]);
    case (mode)
      MODE_MEM: dec_val = DATA_W'(shift_operand);
      MODE_IMM_ROT: begin
        dec_work = DATA_W'(shift_operand[7:0]);
        dec_type = ROR;
        dec_val  = DATA_W'(shift_operand[7:0]);
        if (shift_operand[11:8] != 4'd0) begin
          dec_special = 1'b0;
          dec_n       = {shift_operand[11:8], 1'b0};
        end
      end
      MODE_REG_IMM: begin
        dec_val = rm;
        if (shift_operand[11:7] != 5'd0) begin
          dec_special = 1'b0;
          dec_n       = shift_operand[11:7];
        end else begin
          case (dec_type)
            LSL: dec_carry = carry_in;
            LSR: begin
              dec_val   = '0;
              dec_carry = rm[DATA_W-1];
            end
            ASR: begin
              dec_val   = {DATA_W{rm[DATA_W-1]}};
              dec_carry = rm[DATA_W-1];
            end
            default: begin
              dec_val   = {carry_in, rm[DATA_W-1:1]};
              dec_carry = rm[0];
            end
          endcase
        end
      end
      MODE_REG_REG: begin
        dec_val = rm;
        if (rs != 8'd0) begin
          case (dec_type)
            LSL, LSR: begin
              if (rs < 8'd32) begin
                dec_special = 1'b0;
                dec_n       = rs[4:0];
              end else begin
                dec_val   = '0;
                dec_carry = (rs == 8'd32) ? ((dec_type == LSL) ? rm[0] : rm[DATA_W-1]) : 1'b0;
              end
            end
            ASR: begin
              if (rs < 8'd32) begin
                dec_special = 1'b0;
                dec_n       = rs[4:0];
              end else begin
                dec_val   = {DATA_W{rm[DATA_W-1]}};
                dec_carry = rm[DATA_W-1];
              end
            end
            default: begin
              if (rs[4:0] == 5'd0) begin
                dec_carry = rm[DATA_W-1];
              end else begin
                dec_special = 1'b0;
                dec_n       = rs[4:0];
              end
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign n_wide = {1'b0, n_q};
  assign step_k = (n_wide > 6'(STEP)) ? KW'(STEP) : KW'(n_wide);

  val2_shift_step #(.STEP_LOG2(STEP_LOG2)) u_step (
    .data     (work_q),
    .k        (step_k),
    .stype    (type_q),
    .carry_in (carry_out),
    .result_c (step_res),
    .carry_c  (step_carry)
  );

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    work_nxt  = work_q;
    n_nxt     = n_q;
    type_nxt  = type_q;
    val_nxt   = val2_out;
    cout_nxt  = carry_out;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (dec_special) begin
            state_nxt = DONE;
            val_nxt   = dec_val;
            cout_nxt  = dec_carry;
          end else begin
            state_nxt = SHIFT;
            work_nxt  = dec_work;
            n_nxt     = dec_n;
            type_nxt  = dec_type;
          end
        end
      end
      SHIFT: begin
        work_nxt = step_res;
        n_nxt    = n_q - 5'(step_k);
        if (n_wide == 6'(step_k)) begin
          state_nxt = DONE;
          val_nxt   = step_res;
          cout_nxt  = step_carry;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flush behaves exactly like reset and wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      work_q    <= '0;
      n_q       <= '0;
      type_q    <= LSL;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      val2_out  <= '0;
      carry_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      work_q    <= work_nxt;
      n_q       <= n_nxt;
      type_q    <= type_nxt;
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == DONE);
      val2_out  <= val_nxt;
      carry_out <= cout_nxt;
    end
  end

endmodule

// File: tb/tb_val2_seq_shifter.sv
// Bench for val2_seq_shifter: six instances (STEP_LOG2 0..5) on shared stimulus,
// checked every cycle against an arithmetic reference plus literal expectations.
module tb_val2_seq_shifter;

  localparam int NI = 6;
  localparam int MAIN = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [2:0]  mode;
  logic [11:0] sh;
  logic [31:0] rm;
  logic [7:0]  rs;
  logic [31:0] imm32;
  logic        carry_in;
  logic        out_ready;

  logic [NI-1:0] in_ready_v;
  logic [NI-1:0] out_valid_v;
  logic [NI-1:0] carry_v;
  logic [NI-1:0] busy_v;
  logic [31:0]   val_a [NI];

  int n_cmp;
  int n_bad;
  bit armed;

  // reference state per instance
  bit          pend [NI];
  int          rem  [NI];
  logic [31:0] ev   [NI];
  logic        ec   [NI];
  bit          clr  [NI];

  int          lat_seen [NI];
  logic [31:0] val_seen [NI];
  logic        c_seen   [NI];
  int          sweep_lat [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    val2_seq_shifter #(.STEP_LOG2(g)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready_v[g]),
      .mode          (mode),
      .shift_operand (sh),
      .rm            (rm),
      .rs            (rs),
      .imm32         (imm32),
      .carry_in      (carry_in),
      .out_valid     (out_valid_v[g]),
      .out_ready     (out_ready),
      .val2_out      (val_a[g]),
      .carry_out     (carry_v[g]),
      .busy          (busy_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void shift_ref(input logic [31:0] r, input int t, input int n,
                                    output logic [31:0] v, output logic c);
    logic [63:0] w;
    case (t)
      0: begin v = r << n; c = r[32-n]; end
      1: begin v = r >> n; c = r[n-1]; end
      2: begin v = 32'($signed(r) >>> n); c = r[n-1]; end
      default: begin w = {r, r} >> n; v = w[31:0]; c = v[31]; end
    endcase
  endfunction

  // Architectural result and latency of one request.
  function automatic void ref_val2(input logic [2:0] md, input logic [11:0] s_op,
                                   input logic [31:0] r, input logic [7:0] s,
                                   input logic [31:0] im, input logic ci, input int sl,
                                   output logic [31:0] v, output logic c, output int lat);
    int n;
    int t;
    int stp;
    n = 0;
    t = int'(s_op[6:5]);
    v = im;
    c = ci;
    case (md)
      3'd1: v = {20'b0, s_op};
      3'd2: begin
        v = {24'b0, s_op[7:0]};
        n = 2 * int'(s_op[11:8]);
        if (n != 0) shift_ref(v, 3, n, v, c);
      end
      3'd3: begin
        v = r;
        n = int'(s_op[11:7]);
        if (n != 0) shift_ref(r, t, n, v, c);
        else if (t == 1) begin v = 32'd0; c = r[31]; end
        else if (t == 2) begin v = {32{r[31]}}; c = r[31]; end
        else if (t == 3) begin v = {ci, r[31:1]}; c = r[0]; end
      end
      3'd4: begin
        v = r;
        if (s != 8'd0) begin
          if (t == 3) begin
            if (s[4:0] == 5'd0) c = r[31];
            else n = int'(s[4:0]);
          end else if (s < 8'd32) begin
            n = int'(s);
          end else if (t == 2) begin
            v = {32{r[31]}}; c = r[31];
          end else begin
            v = 32'd0;
            c = (s == 8'd32) ? ((t == 0) ? r[0] : r[31]) : 1'b0;
          end
          if (n != 0) shift_ref(r, t, n, v, c);
        end
      end
      default: ;
    endcase
    stp = 1 << sl;
    lat = (n == 0) ? 1 : (n + stp - 1) / stp + 1;
  endfunction

  // Reference timing: advances on every clock edge from sampled inputs.
  initial begin
    int lat;
    forever begin
      @(posedge clk);
      for (int g = 0; g < NI; g++) begin
        if (rst || flush) begin
          pend[g] = 1'b0;
          clr[g]  = 1'b1;
        end else if (pend[g]) begin
          if (rem[g] == 0) begin
            if (out_ready) pend[g] = 1'b0;
          end else begin
            rem[g]--;
          end
        end else if (in_valid) begin
          ref_val2(mode, sh, rm, rs, imm32, carry_in, g, ev[g], ec[g], lat);
          pend[g] = 1'b1;
          rem[g]  = lat - 1;
          clr[g]  = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the reference.
  initial begin
    bit vexp;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int g = 0; g < NI; g++) begin
          vexp = pend[g] && (rem[g] == 0);
          chk($sformatf("g%0d out_valid", g), 32'(out_valid_v[g]), 32'(vexp));
          chk($sformatf("g%0d in_ready", g), 32'(in_ready_v[g]), 32'(!pend[g]));
          chk($sformatf("g%0d busy", g), 32'(busy_v[g]), 32'(pend[g]));
          if (vexp) begin
            chk($sformatf("g%0d val2_out", g), val_a[g], ev[g]);
            chk($sformatf("g%0d carry_out", g), 32'(carry_v[g]), 32'(ec[g]));
          end
          if (clr[g]) begin
            chk($sformatf("g%0d cleared val2_out", g), val_a[g], 32'd0);
            chk($sformatf("g%0d cleared carry_out", g), 32'(carry_v[g]), 32'd0);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (&in_ready_v) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle timeout", 32'd0, 32'd1);
  endtask

  // Issue one request at a negedge; record first-valid latency of every instance.
  task automatic do_op(input string nm, input logic [2:0] md, input logic [11:0] s_op,
                       input logic [31:0] r, input logic [7:0] s, input logic [31:0] im,
                       input logic ci, input logic [31:0] xv, input logic xc, input int xl);
    int  cyc;
    bit  all;
    for (int g = 0; g < NI; g++) begin
      lat_seen[g] = -1;
      val_seen[g] = 32'hxxxx_xxxx;
      c_seen[g]   = 1'bx;
    end
    mode = md; sh = s_op; rm = r; rs = s; imm32 = im; carry_in = ci;
    in_valid = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 60; t++) begin
      all = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (lat_seen[g] < 0) begin
          if (out_valid_v[g]) begin
            lat_seen[g] = cyc;
            val_seen[g] = val_a[g];
            c_seen[g]   = carry_v[g];
          end else begin
            all = 1'b0;
          end
        end
      end
      if (all) break;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({nm, " value"}, val_seen[MAIN], xv);
    chk({nm, " carry"}, 32'(c_seen[MAIN]), 32'(xc));
    chk({nm, " latency"}, 32'(lat_seen[MAIN]), 32'(xl));
    if (out_ready) wait_idle();
  endtask

  // Abort an ROR #31 in its second shift cycle with rst or flush.
  task automatic abort_op(input bit use_rst);
    mode = 3'd3; sh = 12'hFE0; rm = 32'h8000_0001; rs = 8'd0; carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    chk(use_rst ? "rst out_valid" : "flush out_valid", 32'(out_valid_v[MAIN]), 32'd0);
    chk(use_rst ? "rst in_ready" : "flush in_ready", 32'(in_ready_v[MAIN]), 32'd1);
    chk(use_rst ? "rst busy" : "flush busy", 32'(busy_v[MAIN]), 32'd0);
    if (use_rst) chk("rst val2_out", val_a[MAIN], 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort out_valid stays low", 32'(out_valid_v[MAIN]), 32'd0);
    end
  endtask

  initial begin
    sweep_lat = '{14, 8, 5, 3, 2, 2};
    n_cmp = 0; n_bad = 0; armed = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = '0; sh = '0; rm = '0; rs = '0; imm32 = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    chk("reset out_valid", 32'(out_valid_v[MAIN]), 32'd0);
    chk("reset busy", 32'(busy_v[MAIN]), 32'd0);
    chk("reset val2_out", val_a[MAIN], 32'd0);
    chk("reset carry_out", 32'(carry_v[MAIN]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle in_ready", 32'(in_ready_v[MAIN]), 32'd1);

    do_op("imm_rot 0x4FF", 3'd2, 12'h4FF, 32'h0, 8'h0, 32'h0, 1'b0, 32'hFF00_0000, 1'b1, 3);
    do_op("lsr #0", 3'd3, 12'h020, 32'h8000_0001, 8'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    do_op("rrx", 3'd3, 12'h060, 32'h0000_0003, 8'h0, 32'h0, 1'b1, 32'h8000_0001, 1'b1, 1);
    do_op("reg lsl 32", 3'd4, 12'h010, 32'hFFFF_FFFF, 8'h20, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    do_op("reg lsl 33", 3'd4, 12'h010, 32'hFFFF_FFFF, 8'h21, 32'h0, 1'b1, 32'h0, 1'b0, 1);
    do_op("reg lsl 0", 3'd4, 12'h010, 32'hFFFF_FFFF, 8'h00, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1);
    do_op("reg lsr 4", 3'd4, 12'h030, 32'hF000_0018, 8'h04, 32'h0, 1'b0, 32'h0F00_0001, 1'b1, 2);
    do_op("reg asr 40", 3'd4, 12'h050, 32'h8000_0000, 8'h28, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1);
    do_op("reg ror 64", 3'd4, 12'h070, 32'h8000_0001, 8'h40, 32'h0, 1'b0, 32'h8000_0001, 1'b1, 1);
    do_op("mem", 3'd1, 12'hABC, 32'h0, 8'h0, 32'h0, 1'b1, 32'h0000_0ABC, 1'b1, 1);
    do_op("imm32", 3'd0, 12'h0, 32'h0, 8'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1);
    do_op("mode 7", 3'd7, 12'hFFF, 32'h1, 8'h1, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 1);

    // Held result while the consumer stalls.
    out_ready = 1'b0;
    do_op("asr #5", 3'd3, 12'h2C0, 32'h8000_0000, 8'h0, 32'h0, 1'b1, 32'hFC00_0000, 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold val2_out", val_a[MAIN], 32'hFC00_0000);
      chk("hold carry_out", 32'(carry_v[MAIN]), 32'd0);
      chk("hold out_valid", 32'(out_valid_v[MAIN]), 32'd1);
      chk("hold in_ready", 32'(in_ready_v[MAIN]), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle();

    do_op("ror #13", 3'd3, 12'h6E0, 32'h1234_5678, 8'h0, 32'h0, 1'b0, 32'hB3C0_91A2, 1'b1, 5);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("sweep g%0d latency", g), 32'(lat_seen[g]), 32'(sweep_lat[g]));
      chk($sformatf("sweep g%0d value", g), val_seen[g], 32'hB3C0_91A2);
      chk($sformatf("sweep g%0d carry", g), 32'(c_seen[g]), 32'd1);
    end

    abort_op(1'b0);
    wait_idle();
    do_op("imm32 refill", 3'd0, 12'h0, 32'h0, 8'h0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1);
    abort_op(1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/val2_seq_shifter.md
Name: val2_seq_shifter

Overview:
- Multi-cycle successor to the combinational Val2 operand generator in the EXE stage.
- Produces the ARM operand-2 value and shifter carry-out for all operand modes: 32-bit immediate, memory offset, rotated imm8, register shifted by immediate, and register shifted by register.
- Shifts are performed iteratively, STEP positions per cycle, behind a valid/ready handshake, so the pipeline can trade latency for area.

Parameters:
- STEP_LOG2, 2: log2 of the shift positions per cycle. Legal range 0..5; 5 gives single-cycle shifting.
- DATA_W, 32: operand width. Fixed at 32 by the ARM encodings; exposed for package consistency only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; discards any operation in flight
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- mode  in  3  0=IMM32, 1=MEM, 2=IMM_ROT, 3=REG_IMM, 4=REG_REG; 5-7 are treated as IMM32
- shift_operand  in  12  instruction bits [11:0]
- rm  in  32  Rm value
- rs  in  8  Rs[7:0], shift amount for REG_REG
- imm32  in  32  full immediate for IMM32
- carry_in  in  1  CPSR C flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- val2_out  out  32  operand 2
- carry_out  out  1  shifter carry-out
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; out_valid=0, val2_out=0, carry_out=0, busy=0.
  - An operation in progress is discarded.
- flush: identical effect to reset, with priority over every other event. A request handshaking in the same cycle is dropped.
- States and transitions:
  - IDLE: in_ready=1. Accept on in_valid&in_ready. Special cases go directly to DONE; all others load work_reg, remaining count n and type, then go to SHIFT.
  - SHIFT: each cycle shifts work_reg by min(2^STEP_LOG2, n), decrements n, and records the last bit shifted out as carry. When n reaches 0, go to DONE.
  - DONE: out_valid=1. val2_out and carry_out are held stable until out_ready=1, then go to IDLE.
  - in_ready=0 outside IDLE; there is no back-to-back overlap.
- Latency from the accept edge to out_valid:
  - Special case: 1 cycle.
  - Otherwise: ceil(n / 2^STEP_LOG2) + 1 cycles.
- Special cases (resolved at accept, going straight to DONE):
  - IMM32: val=imm32, C=carry_in.
  - MEM: val={20'b0, shift_operand}, C=carry_in.
  - IMM_ROT with rot=sh[11:8]=0: val=zero-extended imm8, C=carry_in.
  - REG_IMM, amt=sh[11:7]=0, type=sh[6:5]:
    - LSL: rm, carry_in.
    - LSR: 0, rm[31].
    - ASR: {32{rm[31]}}, rm[31].
    - ROR (RRX): {carry_in, rm[31:1]}, rm[0].
  - REG_REG with rs=0: rm, carry_in.
  - REG_REG LSL: rs=32 gives 0, rm[0]; rs>32 gives 0, 0.
  - REG_REG LSR: rs=32 gives 0, rm[31]; rs>32 gives 0, 0.
  - REG_REG ASR with rs>=32: {32{rm[31]}}, rm[31].
  - REG_REG ROR with rs!=0 and rs[4:0]=0: rm, rm[31].
- Iterative cases:
  - IMM_ROT: ROR of imm8 by n=2*rot.
  - REG_IMM: n=amt for amt 1..31.
  - REG_REG: n=rs for rs 1..31; ROR with rs>=32 uses n=rs[4:0].
- Shift semantics per step:
  - LSL fills with 0.
  - LSR fills with 0.
  - ASR fills with bit 31.
  - ROR wraps around.
- Carry rule: carry_out is the last bit shifted out. For ROR this equals result bit 31.
- out_valid is never asserted without a preceding accepted request.

Decomposition:
- Package val2_pkg holds:
  - the mode enum and the shift-type enum (LSL/LSR/ASR/ROR);
  - the FSM state enum (IDLE/SHIFT/DONE);
  - DATA_W.
- One sub-module, val2_shift_step: a combinational single step that shifts by k ≤ 2^STEP_LOG2 and returns the result plus the last bit out. The top instantiates it once.

Test Plan:
- IMM_ROT, sh=0x4FF, STEP_LOG2=2 → val2_out=0xFF000000, carry_out=1; n=8, so out_valid arrives 3 cycles after accept.
- REG_IMM LSR #0 (sh=0x020), rm=0x80000001 → val2_out=0, carry_out=1, latency 1. RRX (sh=0x060), rm=0x00000003, carry_in=1 → 0x80000001, carry_out=1.
- REG_REG LSL (sh=0x010), rm=0xFFFFFFFF:
  - rs=0x20 → 0, carry_out=1.
  - rs=0x21 → 0, carry_out=0.
  - rs=0x00 → 0xFFFFFFFF, carry_out=carry_in.
- REG_IMM ASR #5 (sh=0x2C0), rm=0x80000000 → 0xFC000000, carry_out=0. Hold out_ready=0 for 4 cycles → outputs stable and in_ready=0 throughout.
- flush asserted in the 2nd SHIFT cycle of an ROR #31 → IDLE next cycle, out_valid stays 0, in_ready=1. Repeat with rst in place of flush → same result, plus val2_out=0.
- MEM, sh=0xABC → val2_out=0x00000ABC. IMM32 with imm32=0xDEADBEEF → 0xDEADBEEF. Sweep STEP_LOG2 over 0..5 for ROR #13 on rm=0x12345678 → identical value and carry, with latency ceil(13/2^STEP_LOG2)+1.
